// File: rtl/ftq_queue.sv
// Fetch Target Queue: a circular buffer of predicted fetch blocks between the
// branch predictor and the ICache. Entries are written at the enqueue pointer,
// handed to the ICache in order at the issue pointer, and held until the
// backend retires them at the commit pointer.
//
// Handshakes: BpValid has no ready signal. The BPU is throttled through
// FtqReq and the frontend control block (FTQStop), so a block offered while
// Full or stopped is dropped. IcValid/IcReady is a plain valid/ready pair:
// the entry at the issue pointer transfers on any edge where both are high.
// IcValid never depends on IcReady. CommitValid retires the oldest issued
// entry and is ignored when no issued entry is waiting to retire.
module ftq_queue #(
    parameter int DEPTH = 8,
    parameter int PTRW  = 3,
    parameter int ADDRW = 32
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             FTQStop,
    input  logic             FTQFlash,
    input  logic             BpValid,
    input  logic [ADDRW-1:0] BpPc,
    input  logic [ADDRW-1:0] BpTarget,
    input  logic             BpTaken,
    output logic             FtqReq,
    output logic             IcValid,
    input  logic             IcReady,
    output logic [ADDRW-1:0] IcPc,
    output logic [ADDRW-1:0] IcTarget,
    output logic             IcTaken,
    output logic [PTRW-1:0]  IcFtqIdx,
    input  logic             CommitValid,
    output logic [PTRW:0]    FtqCount
);

    // Pointers carry one extra wrap bit so that full and empty are distinct.
    localparam logic [PTRW:0] DEPTH_W  = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0] ALMOST_W = DEPTH_W - 1'b1;

    logic [ADDRW-1:0] pc_mem  [DEPTH];
    logic [ADDRW-1:0] tgt_mem [DEPTH];
    logic             tkn_mem [DEPTH];

    logic [PTRW:0]   enq_ptr;
    logic [PTRW:0]   iss_ptr;
    logic [PTRW:0]   cmt_ptr;
    logic [PTRW:0]   count;
    logic [PTRW:0]   count_next;
    logic [PTRW-1:0] enq_idx;
    logic [PTRW-1:0] iss_idx;
    logic            full;
    logic            pending;
    logic            do_enq;
    logic            do_iss;
    logic            do_cmt;
    logic            req_next;

    assign count   = enq_ptr - cmt_ptr;
    assign full    = (count == DEPTH_W);
    assign pending = (iss_ptr != enq_ptr);
    assign enq_idx = enq_ptr[PTRW-1:0];
    assign iss_idx = iss_ptr[PTRW-1:0];

    // Flush dominates everything. Full is judged on the current pointers, so a
    // same-cycle commit does not open a slot for this cycle's enqueue.
    assign do_enq = BpValid & ~FTQStop & ~full & ~FTQFlash;
    assign do_iss = IcValid & IcReady;
    assign do_cmt = CommitValid & (cmt_ptr != iss_ptr) & ~FTQFlash;

    // Issue side reads the array combinationally. Outputs are zeroed while
    // nothing is pending, so unreset storage never leaks out after reset.
    always_comb begin
        IcValid  = pending & ~FTQFlash;
        IcPc     = '0;
        IcTarget = '0;
        IcTaken  = 1'b0;
        IcFtqIdx = '0;
        if (pending) begin
            IcPc     = pc_mem[iss_idx];
            IcTarget = tgt_mem[iss_idx];
            IcTaken  = tkn_mem[iss_idx];
            IcFtqIdx = iss_idx;
        end
    end

    // Next occupancy feeds the registered almost-full request. One free slot
    // or fewer raises FtqReq, leaving room for the block already in flight.
    always_comb begin
        count_next = count + {{PTRW{1'b0}}, do_enq} - {{PTRW{1'b0}}, do_cmt};
        if (FTQFlash) begin
            count_next = '0;
        end
        req_next = (count_next >= ALMOST_W);
    end

    assign FtqCount = count;

    // Entry storage: written at the enqueue index, not reset.
    always_ff @(posedge Clk) begin
        if (do_enq) begin
            pc_mem[enq_idx]  <= BpPc;
            tgt_mem[enq_idx] <= BpTarget;
            tkn_mem[enq_idx] <= BpTaken;
        end
    end

    // Pointer and request state; flush returns everything to the reset image.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            enq_ptr <= '0;
            iss_ptr <= '0;
            cmt_ptr <= '0;
            FtqReq  <= 1'b0;
        end else if (FTQFlash) begin
            enq_ptr <= '0;
            iss_ptr <= '0;
            cmt_ptr <= '0;
            FtqReq  <= 1'b0;
        end else begin
            if (do_enq) enq_ptr <= enq_ptr + 1'b1;
            if (do_iss) iss_ptr <= iss_ptr + 1'b1;
            if (do_cmt) cmt_ptr <= cmt_ptr + 1'b1;
            FtqReq <= req_next;
        end
    end

endmodule

// File: tb/tb_ftq_queue.sv
// Directed bench for ftq_queue with an entry scoreboard and occupancy model.
module tb_ftq_queue;
    localparam int DEPTH = 8;
    localparam int PTRW  = 3;
    localparam int ADDRW = 32;

    logic             Clk = 1'b0;
    logic             Rest;
    logic             FTQStop;
    logic             FTQFlash;
    logic             BpValid;
    logic [ADDRW-1:0] BpPc;
    logic [ADDRW-1:0] BpTarget;
    logic             BpTaken;
    logic             FtqReq;
    logic             IcValid;
    logic             IcReady;
    logic [ADDRW-1:0] IcPc;
    logic [ADDRW-1:0] IcTarget;
    logic             IcTaken;
    logic [PTRW-1:0]  IcFtqIdx;
    logic             CommitValid;
    logic [PTRW:0]    FtqCount;

    ftq_queue #(.DEPTH(DEPTH), .PTRW(PTRW), .ADDRW(ADDRW)) dut (
        .Clk(Clk), .Rest(Rest), .FTQStop(FTQStop), .FTQFlash(FTQFlash),
        .BpValid(BpValid), .BpPc(BpPc), .BpTarget(BpTarget), .BpTaken(BpTaken),
        .FtqReq(FtqReq), .IcValid(IcValid), .IcReady(IcReady), .IcPc(IcPc),
        .IcTarget(IcTarget), .IcTaken(IcTaken), .IcFtqIdx(IcFtqIdx),
        .CommitValid(CommitValid), .FtqCount(FtqCount)
    );

    // Clock
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {pc, target, taken, idx}
    logic [67:0] exp_q[$];
    int   m_enq;
    int   m_iss;
    int   m_cmt;
    logic m_req;

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_enq = 0;
        m_iss = 0;
        m_cmt = 0;
        m_req = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_idle();
        FTQStop     = 1'b0;
        FTQFlash    = 1'b0;
        BpValid     = 1'b0;
        BpPc        = '0;
        BpTarget    = '0;
        BpTaken     = 1'b0;
        IcReady     = 1'b0;
        CommitValid = 1'b0;
    endtask

    // One clock: at the falling edge compare the DUT against the model, then
    // advance the model with the inputs the DUT will sample on the rising edge.
    task automatic cycle();
        int   cnt;
        int   iss_old;
        bit   full;
        bit   pending;
        logic [67:0] exp_e;
        @(negedge Clk);
        cnt     = m_enq - m_cmt;
        full    = (cnt == DEPTH);
        pending = (m_iss != m_enq);
        iss_old = m_iss;
        check("ftq_count", 68'(FtqCount), 68'(cnt));
        check("ftq_req", 68'(FtqReq), 68'(m_req));
        check("ic_valid", 68'(IcValid), 68'(pending && !FTQFlash));
        if (!pending)
            check("ic_idle_zero", {IcPc, IcTarget, IcTaken, IcFtqIdx}, 68'(0));
        if (FTQFlash) begin
            model_clear();
        end else begin
            if (pending && IcReady) begin
                exp_e = exp_q.pop_front();
                check("ic_entry", {IcPc, IcTarget, IcTaken, IcFtqIdx}, exp_e);
                m_iss++;
            end
            if (CommitValid && (m_cmt != iss_old)) m_cmt++;
            if (BpValid) begin
                if (!FTQStop && !full) begin
                    exp_q.push_back({BpPc, BpTarget, BpTaken, 3'(m_enq % DEPTH)});
                    m_enq++;
                end else begin
                    $display("note: block dropped pc=%h", BpPc);
                end
            end
            cnt   = m_enq - m_cmt;
            m_req = ((DEPTH - cnt) <= 1);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rest = 1'b1;
        model_clear();
        #1;
        check("rst_ic_valid", 68'(IcValid), 68'(0));
        check("rst_ftq_req", 68'(FtqReq), 68'(0));
        check("rst_ftq_count", 68'(FtqCount), 68'(0));
        check("rst_ic_data", {IcPc, IcTarget, IcTaken, IcFtqIdx}, 68'(0));
        @(posedge Clk);
        #1;
        Rest = 1'b0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] tgt, input logic tkn);
        BpValid  = 1'b1;
        BpPc     = pc;
        BpTarget = tgt;
        BpTaken  = tkn;
        cycle();
        BpValid  = 1'b0;
    endtask

    initial begin
        set_idle();
        do_reset();

        // First block becomes visible the cycle after it is written.
        enq(32'h1C00_0000, 32'h1C00_0010, 1'b1);
        check("t1_ic_valid", 68'(IcValid), 68'(1));
        check("t1_ic_pc", 68'(IcPc), 68'(32'h1C00_0000));
        check("t1_ic_idx", 68'(IcFtqIdx), 68'(0));
        check("t1_count", 68'(FtqCount), 68'(1));
        cycle();

        // Fill: request after the 7th, 8th accepted, 9th dropped.
        do_reset();
        for (int i = 0; i < 7; i++)
            enq(32'h0000_1000 + 32'(i * 16), $urandom, 1'($urandom_range(0, 1)));
        check("t2_req_at7", 68'(FtqReq), 68'(1));
        check("t2_count7", 68'(FtqCount), 68'(7));
        enq(32'h0000_1070, 32'h0000_2000, 1'b0);
        check("t2_count8", 68'(FtqCount), 68'(8));
        enq(32'hDEAD_BEE0, 32'hDEAD_0000, 1'b1);
        check("t2_count_drop", 68'(FtqCount), 68'(8));
        check("t2_head_pc", 68'(IcPc), 68'(32'h0000_1000));
        IcReady = 1'b1;
        repeat (8) cycle();
        IcReady = 1'b0;
        check("t2_all_issued", 68'(IcValid), 68'(0));
        // Full with same-cycle commit: the enqueue is still refused.
        BpValid     = 1'b1;
        BpPc        = 32'hBEEF_0000;
        CommitValid = 1'b1;
        cycle();
        BpValid     = 1'b0;
        check("t2_count_c1", 68'(FtqCount), 68'(7));
        check("t2_req_c1", 68'(FtqReq), 68'(1));
        cycle();
        CommitValid = 1'b0;
        check("t2_count_c2", 68'(FtqCount), 68'(6));
        check("t2_req_c2", 68'(FtqReq), 68'(0));
        cycle();

        // Steady state with enqueue, issue and commit every cycle; wraps.
        do_reset();
        IcReady     = 1'b1;
        CommitValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            BpValid  = 1'b1;
            BpPc     = 32'h4000_0000 + 32'(i * 32);
            BpTarget = $urandom;
            BpTaken  = 1'($urandom_range(0, 1));
            cycle();
        end
        BpValid = 1'b0;
        repeat (3) cycle();
        check("t3_drained", 68'(FtqCount), 68'(0));
        IcReady     = 1'b0;
        CommitValid = 1'b0;

        // Flush with concurrent enqueue and commit.
        do_reset();
        for (int i = 0; i < 5; i++)
            enq(32'h5000_0000 + 32'(i * 4), $urandom, 1'b0);
        IcReady = 1'b1;
        repeat (3) cycle();
        IcReady     = 1'b0;
        CommitValid = 1'b1;
        cycle();
        check("t4_count_pre", 68'(FtqCount), 68'(4));
        FTQFlash = 1'b1;
        BpValid  = 1'b1;
        BpPc     = 32'h0BAD_0000;
        IcReady  = 1'b1;
        #1;
        check("t4_flush_ic_valid", 68'(IcValid), 68'(0));
        cycle();
        set_idle();
        check("t4_count_post", 68'(FtqCount), 68'(0));
        check("t4_valid_post", 68'(IcValid), 68'(0));
        enq(32'h6000_0000, 32'h6000_0040, 1'b1);
        check("t4_new_idx", 68'(IcFtqIdx), 68'(0));
        check("t4_new_pc", 68'(IcPc), 68'(32'h6000_0000));
        IcReady = 1'b1;
        cycle();
        IcReady = 1'b0;

        // Flush while full releases the request.
        do_reset();
        for (int i = 0; i < 8; i++)
            enq(32'h7000_0000 + 32'(i * 4), $urandom, 1'b1);
        check("t5_req_full", 68'(FtqReq), 68'(1));
        FTQFlash = 1'b1;
        cycle();
        FTQFlash = 1'b0;
        check("t5_req_flushed", 68'(FtqReq), 68'(0));

        // Asynchronous reset mid-cycle while full.
        for (int i = 0; i < 8; i++)
            enq(32'h8000_0000 + 32'(i * 4), $urandom, 1'b0);
        check("t6_count_full", 68'(FtqCount), 68'(8));
        @(negedge Clk);
        #2;
        Rest = 1'b1;
        #1;
        check("t6_async_valid", 68'(IcValid), 68'(0));
        check("t6_async_req", 68'(FtqReq), 68'(0));
        check("t6_async_count", 68'(FtqCount), 68'(0));
        model_clear();
        @(posedge Clk);
        #1;
        Rest = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
